// File: rtl/ace_ccu_read_arb.sv
// Read-path arbiter in front of the CCU: round-robin merge of the shareable AR streams with the
// source port index prepended to the ID, a per-port outstanding-read limit, and R routing by ID MSBs.
package ace_ccu_read_arb_pkg;
  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } slv_ar_chan_t;

  typedef struct packed {
    logic [5:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } mst_ar_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [3:0]  resp;
    logic        last;
  } slv_r_chan_t;

  typedef struct packed {
    logic [5:0]  id;
    logic [63:0] data;
    logic [3:0]  resp;
    logic        last;
  } mst_r_chan_t;
endpackage

module ace_ccu_read_arb #(
  parameter int unsigned NoSlvPorts = 4,
  parameter int unsigned AxiIdWidth = 4,
  parameter int unsigned MaxTrans   = 8,
  parameter type slv_ar_chan_t = ace_ccu_read_arb_pkg::slv_ar_chan_t,
  parameter type mst_ar_chan_t = ace_ccu_read_arb_pkg::mst_ar_chan_t,
  parameter type slv_r_chan_t  = ace_ccu_read_arb_pkg::slv_r_chan_t,
  parameter type mst_r_chan_t  = ace_ccu_read_arb_pkg::mst_r_chan_t
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  slv_ar_chan_t          slv_ar_i [NoSlvPorts],
  input  logic [NoSlvPorts-1:0] slv_ar_valid_i,
  output logic [NoSlvPorts-1:0] slv_ar_ready_o,
  output slv_r_chan_t           slv_r_o [NoSlvPorts],
  output logic [NoSlvPorts-1:0] slv_r_valid_o,
  input  logic [NoSlvPorts-1:0] slv_r_ready_i,
  output mst_ar_chan_t          mst_ar_o,
  output logic                  mst_ar_valid_o,
  input  logic                  mst_ar_ready_i,
  input  mst_r_chan_t           mst_r_i,
  input  logic                  mst_r_valid_i,
  output logic                  mst_r_ready_o,
  output logic                  route_err_o
);
  localparam int unsigned IdxW  = (NoSlvPorts == 1) ? 1 : $clog2(NoSlvPorts);
  localparam int unsigned CntW  = $clog2(MaxTrans + 1);
  localparam int unsigned SlvRW = $bits(slv_r_chan_t);

  logic [IdxW-1:0]       rr_q;
  logic [CntW-1:0]       cnt_q [NoSlvPorts];
  logic [NoSlvPorts-1:0] eligible;
  logic [NoSlvPorts-1:0] r_dec;
  logic                  gnt_vld;
  logic [IdxW-1:0]       gnt_idx;
  logic                  ar_load;
  logic                  ar_take;
  logic                  ar_vld_q;
  mst_ar_chan_t          ar_q;
  mst_ar_chan_t          ar_d;
  logic [IdxW-1:0]       r_idx;
  logic                  r_bad;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NoSlvPorts; i++) begin
      eligible[i] = slv_ar_valid_i[i] && (cnt_q[i] < CntW'(MaxTrans));
    end
  end

  // Two passes: ports at or above the pointer first, then wrap around to the lowest index.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < NoSlvPorts; i++) begin
      if (!gnt_vld && eligible[i] && (IdxW'(i) >= rr_q)) begin
        gnt_vld = 1'b1;
        gnt_idx = IdxW'(i);
      end
    end
    for (int i = 0; i < NoSlvPorts; i++) begin
      if (!gnt_vld && eligible[i]) begin
        gnt_vld = 1'b1;
        gnt_idx = IdxW'(i);
      end
    end
  end

  assign ar_load = !ar_vld_q || mst_ar_ready_i;
  assign ar_take = ar_load && gnt_vld && !rst_i;

  always_comb begin
    slv_ar_ready_o = '0;
    for (int i = 0; i < NoSlvPorts; i++) begin
      slv_ar_ready_o[i] = ar_take && (gnt_idx == IdxW'(i));
    end
  end

  // The ID is the leading field of both channel types, so prepending the index extends the ID.
  assign ar_d           = mst_ar_chan_t'({gnt_idx, slv_ar_i[gnt_idx]});
  assign mst_ar_o       = ar_q;
  assign mst_ar_valid_o = ar_vld_q;

  assign r_idx = mst_r_i.id[AxiIdWidth+IdxW-1:AxiIdWidth];
  assign r_bad = (32'(r_idx) >= NoSlvPorts);

  always_comb begin
    slv_r_valid_o = '0;
    mst_r_ready_o = 1'b1;
    r_dec         = '0;
    for (int i = 0; i < NoSlvPorts; i++) begin
      slv_r_o[i] = slv_r_chan_t'(mst_r_i[SlvRW-1:0]);
      if (r_idx == IdxW'(i)) begin
        slv_r_valid_o[i] = mst_r_valid_i;
        mst_r_ready_o    = slv_r_ready_i[i];
        r_dec[i]         = mst_r_valid_i && slv_r_ready_i[i] && mst_r_i.last;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ar_vld_q    <= 1'b0;
      ar_q        <= '0;
      rr_q        <= '0;
      route_err_o <= 1'b0;
      for (int i = 0; i < NoSlvPorts; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      if (ar_take) begin
        ar_vld_q <= 1'b1;
        ar_q     <= ar_d;
        rr_q     <= (gnt_idx == IdxW'(NoSlvPorts - 1)) ? '0 : gnt_idx + 1'b1;
      end else if (mst_ar_ready_i) begin
        ar_vld_q <= 1'b0;
      end
      route_err_o <= mst_r_valid_i && r_bad;
      for (int i = 0; i < NoSlvPorts; i++) begin
        if (slv_ar_ready_o[i] && !r_dec[i]) begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end else if (r_dec[i] && !slv_ar_ready_o[i]) begin
          assert (cnt_q[i] != '0);
          if (cnt_q[i] != '0) cnt_q[i] <= cnt_q[i] - 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_ace_ccu_read_arb.sv
// Bench for ace_ccu_read_arb: directed steps plus random traffic checked every cycle against a
// transaction-level model (outstanding counts, round-robin pointer, held AR entry).
module tb_ace_ccu_read_arb;
  import ace_ccu_read_arb_pkg::*;

  localparam int N  = 4;
  localparam int MT = 2;
  localparam int NB = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  slv_ar_chan_t s_ar [N];
  logic [N-1:0] s_ar_vld, s_ar_rdy, s_r_vld, s_r_rdy;
  slv_r_chan_t  s_r [N];
  mst_ar_chan_t m_ar;
  logic         m_ar_vld, m_ar_rdy, m_r_vld, m_r_rdy, rerr;
  mst_r_chan_t  m_r;

  slv_ar_chan_t  b_ar [NB];
  logic [NB-1:0] b_ar_vld, b_ar_rdy, b_r_vld, b_r_rdy;
  slv_r_chan_t   b_r [NB];
  mst_ar_chan_t  b_m_ar;
  logic          b_m_ar_vld, b_m_r_rdy, b_rerr;
  mst_r_chan_t   b_m_r;
  logic          b_m_r_vld;

  ace_ccu_read_arb #(.NoSlvPorts(N), .AxiIdWidth(4), .MaxTrans(MT)) dut (
    .clk_i(clk), .rst_i(rst),
    .slv_ar_i(s_ar), .slv_ar_valid_i(s_ar_vld), .slv_ar_ready_o(s_ar_rdy),
    .slv_r_o(s_r), .slv_r_valid_o(s_r_vld), .slv_r_ready_i(s_r_rdy),
    .mst_ar_o(m_ar), .mst_ar_valid_o(m_ar_vld), .mst_ar_ready_i(m_ar_rdy),
    .mst_r_i(m_r), .mst_r_valid_i(m_r_vld), .mst_r_ready_o(m_r_rdy),
    .route_err_o(rerr)
  );

  ace_ccu_read_arb #(.NoSlvPorts(NB), .AxiIdWidth(4), .MaxTrans(8)) dut_b (
    .clk_i(clk), .rst_i(rst),
    .slv_ar_i(b_ar), .slv_ar_valid_i(b_ar_vld), .slv_ar_ready_o(b_ar_rdy),
    .slv_r_o(b_r), .slv_r_valid_o(b_r_vld), .slv_r_ready_i(b_r_rdy),
    .mst_ar_o(b_m_ar), .mst_ar_valid_o(b_m_ar_vld), .mst_ar_ready_i(1'b1),
    .mst_r_i(b_m_r), .mst_r_valid_i(b_m_r_vld), .mst_r_ready_o(b_m_r_rdy),
    .route_err_o(b_rerr)
  );

  int checks = 0;
  int failures = 0;

  int           cnt_m [N];
  int           rr_m;
  bit           ent_vld;
  mst_ar_chan_t ent;
  mst_ar_chan_t held;
  logic [N-1:0] er;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rand_ar();
    for (int i = 0; i < N; i++) begin
      s_ar[i].id    = 4'($urandom);
      s_ar[i].addr  = $urandom;
      s_ar[i].len   = 8'($urandom);
      s_ar[i].size  = 3'($urandom);
      s_ar[i].burst = 2'($urandom);
    end
  endtask

  // One clock: check outputs mid-cycle against the model, then advance the model across the edge.
  task automatic step();
    int           g;
    int           ridx;
    bit           load;
    logic [N-1:0] exp_rdy, exp_rv;
    slv_r_chan_t  exp_sr;
    mst_ar_chan_t e;
    @(negedge clk);
    g = -1;
    for (int k = 0; k < N; k++) begin
      int p;
      p = (rr_m + k) % N;
      if (g < 0 && s_ar_vld[p] && cnt_m[p] < MT) g = p;
    end
    load = !ent_vld || m_ar_rdy;
    exp_rdy = '0;
    if (!rst && g >= 0 && load) exp_rdy[g] = 1'b1;
    ridx = int'(m_r.id[5:4]);
    exp_rv = '0;
    if (m_r_vld) exp_rv[ridx] = 1'b1;
    exp_sr.id = m_r.id[3:0];
    exp_sr.data = m_r.data;
    exp_sr.resp = m_r.resp;
    exp_sr.last = m_r.last;
    chk("ar_valid", 128'(m_ar_vld), 128'(ent_vld));
    chk("ar_payload", 128'(m_ar), 128'(ent));
    chk("ar_ready", 128'(s_ar_rdy), 128'(exp_rdy));
    chk("r_valid", 128'(s_r_vld), 128'(exp_rv));
    chk("r_ready", 128'(m_r_rdy), 128'(s_r_rdy[ridx]));
    chk("r_payload", 128'(s_r[ridx]), 128'(exp_sr));
    chk("r_payload_other", 128'(s_r[(ridx + 1) % N]), 128'(exp_sr));
    chk("route_err_a", 128'(rerr), 128'(0));
    if (rst) begin
      ent_vld = 1'b0;
      ent = '0;
      rr_m = 0;
      for (int i = 0; i < N; i++) cnt_m[i] = 0;
    end else begin
      if (m_r_vld && s_r_rdy[ridx] && m_r.last) cnt_m[ridx]--;
      if (ent_vld && m_ar_rdy) ent_vld = 1'b0;
      if (exp_rdy != '0) begin
        e.id    = {2'(g), s_ar[g].id};
        e.addr  = s_ar[g].addr;
        e.len   = s_ar[g].len;
        e.size  = s_ar[g].size;
        e.burst = s_ar[g].burst;
        ent = e;
        ent_vld = 1'b1;
        rr_m = (g + 1) % N;
        cnt_m[g]++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    s_ar_vld = '0;
    m_ar_rdy = 1'b1;
    m_r_vld = 1'b0;
    step();
    for (int p = 0; p < N; p++) begin
      while (cnt_m[p] > 0) begin
        m_r.id = {2'(p), 4'($urandom)};
        m_r.data = {$urandom, $urandom};
        m_r.last = 1'b1;
        m_r_vld = 1'b1;
        s_r_rdy = '1;
        step();
      end
    end
    m_r_vld = 1'b0;
    m_r.last = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    rand_ar();
    s_ar_vld = '1;
    m_ar_rdy = 1'b1;
    s_r_rdy = '1;
    m_r = '0;
    m_r.id = 6'b01_0101;
    m_r_vld = 1'b1;
    for (int i = 0; i < NB; i++) b_ar[i] = '0;
    b_ar_vld = '0;
    b_r_rdy = '0;
    b_m_r = '0;
    b_m_r_vld = 1'b0;
    ent_vld = 1'b0;
    ent = '0;
    rr_m = 0;
    for (int i = 0; i < N; i++) cnt_m[i] = 0;

    // Reset: valid upstream is ignored, R routing stays combinational.
    @(posedge clk);
    #1;
    chk("rst_route_err", 128'(rerr), 128'(0));
    repeat (3) step();
    rst = 1'b0;
    s_ar_vld = '0;
    m_r_vld = 1'b0;
    #1;
    chk("rst_ar_valid", 128'(m_ar_vld), 128'(0));

    // Single read from port 2.
    s_ar[2].id = 4'd3;
    s_ar_vld = 4'b0100;
    #1;
    chk("single_rdy", 128'(s_ar_rdy), 128'(4'b0100));
    step();
    s_ar_vld = '0;
    #1;
    chk("single_mvld", 128'(m_ar_vld), 128'(1));
    chk("single_mid", 128'(m_ar.id), 128'(6'b10_0011));
    step();
    m_r.id = 6'b10_0011;
    m_r.last = 1'b1;
    m_r.data = 64'hDEAD_BEEF_0123_4567;
    m_r_vld = 1'b1;
    #1;
    chk("single_rvld", 128'(s_r_vld), 128'(4'b0100));
    chk("single_rid", 128'(s_r[2].id), 128'(3));
    step();
    m_r_vld = 1'b0;

    // Fairness: pointer sits at 3 after granting port 2; two grants per port before the limit.
    s_ar_vld = '1;
    for (int k = 0; k < 2 * N; k++) begin
      #1;
      er = '0;
      er[(3 + k) % N] = 1'b1;
      chk("fair_order", 128'(s_ar_rdy), 128'(er));
      rand_ar();
      step();
    end
    #1;
    chk("fair_all_limited", 128'(s_ar_rdy), 128'(0));
    drain();

    // Backpressure: held entry is stable and nothing is accepted.
    s_ar_vld = 4'b0001;
    m_ar_rdy = 1'b0;
    step();
    s_ar_vld = '1;
    held = m_ar;
    for (int k = 0; k < 5; k++) begin
      rand_ar();
      #1;
      chk("bp_hold", 128'(m_ar), 128'(held));
      chk("bp_vld", 128'(m_ar_vld), 128'(1));
      chk("bp_rdy", 128'(s_ar_rdy), 128'(0));
      step();
    end
    m_ar_rdy = 1'b1;
    #1;
    chk("bp_release", 128'(s_ar_rdy), 128'(4'b0010));
    step();
    drain();

    // Outstanding limit on port 1.
    s_ar_vld = 4'b0010;
    step();
    step();
    s_ar_vld = 4'b1011;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("limit_masked", 128'(s_ar_rdy[1]), 128'(0));
      chk("limit_others", 128'(|s_ar_rdy), 128'(1));
      step();
    end
    s_ar_vld = 4'b0010;
    m_r.id = {2'd1, 4'd7};
    m_r.last = 1'b1;
    m_r_vld = 1'b1;
    s_r_rdy = '1;
    step();
    m_r_vld = 1'b0;
    #1;
    chk("limit_reopen", 128'(s_ar_rdy), 128'(4'b0010));
    step();
    drain();

    // Simultaneous increment and decrement on port 0.
    s_ar_vld = 4'b0001;
    step();
    m_r.id = {2'd0, 4'd1};
    m_r.last = 1'b1;
    m_r_vld = 1'b1;
    step();
    m_r_vld = 1'b0;
    step();
    #1;
    chk("incdec_limit", 128'(s_ar_rdy), 128'(0));
    drain();

    // Reset while the entry is full.
    s_ar_vld = 4'b0001;
    m_ar_rdy = 1'b0;
    step();
    rst = 1'b1;
    step();
    #1;
    chk("midrst_vld", 128'(m_ar_vld), 128'(0));
    chk("midrst_rdy", 128'(s_ar_rdy), 128'(0));
    rst = 1'b0;
    s_ar_vld = '1;
    m_ar_rdy = 1'b1;
    #1;
    chk("midrst_rr", 128'(s_ar_rdy), 128'(4'b0001));
    repeat (3) step();
    drain();

    // Random traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      int p;
      rand_ar();
      s_ar_vld = 4'($urandom);
      m_ar_rdy = ($urandom_range(0, 3) != 0);
      s_r_rdy = 4'($urandom);
      p = $urandom_range(0, N - 1);
      m_r.id = {2'(p), 4'($urandom)};
      m_r.data = {$urandom, $urandom};
      m_r.resp = 4'($urandom);
      m_r.last = (cnt_m[p] > 0) && ($urandom_range(0, 1) == 1);
      m_r_vld = ($urandom_range(0, 2) != 0);
      step();
    end
    drain();

    // Unroutable index on the three-port instance.
    b_m_r.id = {2'd3, 4'd5};
    b_m_r.last = 1'b0;
    b_m_r_vld = 1'b1;
    b_r_rdy = '0;
    #1;
    chk("err_ready", 128'(b_m_r_rdy), 128'(1));
    chk("err_novalid", 128'(b_r_vld), 128'(0));
    chk("err_before", 128'(b_rerr), 128'(0));
    @(posedge clk);
    #1;
    b_m_r_vld = 1'b0;
    chk("err_pulse", 128'(b_rerr), 128'(1));
    @(posedge clk);
    #1;
    chk("err_once", 128'(b_rerr), 128'(0));
    b_m_r.id = {2'd1, 4'd9};
    b_m_r_vld = 1'b1;
    b_r_rdy = 3'b010;
    #1;
    chk("b_route_vld", 128'(b_r_vld), 128'(3'b010));
    chk("b_route_rdy", 128'(b_m_r_rdy), 128'(1));
    chk("b_route_id", 128'(b_r[1].id), 128'(9));
    b_r_rdy = 3'b101;
    #1;
    chk("b_route_stall", 128'(b_m_r_rdy), 128'(0));
    @(posedge clk);
    #1;
    chk("b_no_err", 128'(b_rerr), 128'(0));
    b_m_r_vld = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
